// File: rtl/axi_burst_pkg.sv
// Shared types for the AXI burst address sequencer: burst encoding, FSM states
// and the SIZE-code to byte-count helper.
package axi_burst_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [7:0] size_bytes(input logic [2:0] size);
      return 8'd1 << size;
   endfunction

endpackage

// File: rtl/axi_beat_addr_calc.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Zero latency; no flow control of its own.
module axi_beat_addr_calc
   import axi_burst_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_BITS   = 8
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            size,
   input  burst_t                burst,
   input  logic [LEN_BITS-1:0]   len,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] bytes;
   logic [ADDR_WIDTH-1:0] aligned;
   logic [ADDR_WIDTH-1:0] incr;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      bytes     = ADDR_WIDTH'(size_bytes(size));
      aligned   = addr & ~(bytes - ADDR_WIDTH'(1));
      incr      = aligned + bytes;
      // Wrap window is (LEN+1) beats of 2^SIZE bytes, always a power of two.
      wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      next_addr = addr;
      case (burst)
         BURST_INCR: next_addr = incr;
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:    next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_burst_addr_seq.sv
// AXI burst address sequencer: one command in, LEN+1 beat addresses out, 1-cycle
// accept-to-first-beat, beats held under BEAT_READY low. Optional: BOUNDARY_4K_CHECK_EN.
module axi_burst_addr_seq
   import axi_burst_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_BITS   = 8,
   parameter int unsigned MAX_SIZE   = 3
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [LEN_BITS-1:0]   CMD_LEN,
   input  logic [2:0]            CMD_SIZE,
   input  logic [1:0]            CMD_BURST,
   output logic                  BEAT_VALID,
   input  logic                  BEAT_READY,
   output logic [ADDR_WIDTH-1:0] BEAT_ADDR,
   output logic [LEN_BITS-1:0]   BEAT_IDX,
   output logic                  BEAT_LAST,
   output logic                  CMD_ERR,
   output logic                  BUSY
);

   state_t                state;
   logic [LEN_BITS-1:0]   len_q;
   logic [2:0]            size_q;
   burst_t                burst_q;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  wrap_len_ok;
   logic                  page_cross;
   logic                  cmd_illegal;

   always_comb begin
      wrap_len_ok = (CMD_LEN == LEN_BITS'(1)) || (CMD_LEN == LEN_BITS'(3)) ||
                    (CMD_LEN == LEN_BITS'(7)) || (CMD_LEN == LEN_BITS'(15));
`ifdef BOUNDARY_4K_CHECK_EN
      page_cross = (burst_t'(CMD_BURST) == BURST_INCR) &&
                   ((32'(CMD_ADDR[11:0] & ~(12'(size_bytes(CMD_SIZE)) - 12'd1)) +
                     ((32'(CMD_LEN) + 32'd1) << CMD_SIZE)) > 32'd4096);
`else
      page_cross = 1'b0;
`endif
      cmd_illegal = (burst_t'(CMD_BURST) == BURST_RSVD) ||
                    (32'(CMD_SIZE) > MAX_SIZE) ||
                    ((burst_t'(CMD_BURST) == BURST_WRAP) && !wrap_len_ok) ||
                    page_cross;
   end

   axi_beat_addr_calc #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .LEN_BITS  (LEN_BITS)
   ) u_calc (
      .addr     (BEAT_ADDR),
      .size     (size_q),
      .burst    (burst_q),
      .len      (len_q),
      .next_addr(next_addr)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state      <= ST_IDLE;
         CMD_READY  <= 1'b0;
         BEAT_VALID <= 1'b0;
         BEAT_ADDR  <= '0;
         BEAT_IDX   <= '0;
         BEAT_LAST  <= 1'b0;
         CMD_ERR    <= 1'b0;
         BUSY       <= 1'b0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= BURST_FIXED;
      end else begin
         CMD_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               CMD_READY <= 1'b1;
               if (CMD_VALID && CMD_READY) begin
                  if (cmd_illegal) begin
                     CMD_ERR <= 1'b1;
                  end else begin
                     state      <= ST_RUN;
                     CMD_READY  <= 1'b0;
                     BUSY       <= 1'b1;
                     BEAT_VALID <= 1'b1;
                     BEAT_ADDR  <= CMD_ADDR;
                     BEAT_IDX   <= '0;
                     BEAT_LAST  <= (CMD_LEN == '0);
                     len_q      <= CMD_LEN;
                     size_q     <= CMD_SIZE;
                     burst_q    <= burst_t'(CMD_BURST);
                  end
               end
            end
            ST_RUN: begin
               if (BEAT_READY) begin
                  if (BEAT_LAST) begin
                     state      <= ST_IDLE;
                     BEAT_VALID <= 1'b0;
                     BUSY       <= 1'b0;
                     CMD_READY  <= 1'b1;
                  end else begin
                     BEAT_ADDR <= next_addr;
                     BEAT_IDX  <= BEAT_IDX + LEN_BITS'(1);
                     BEAT_LAST <= (BEAT_IDX + LEN_BITS'(1)) == len_q;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_addr_seq.sv
// Directed bench for axi_burst_addr_seq: command table plus stall and reset sequences.
module tb_axi_burst_addr_seq;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [31:0] CMD_ADDR = '0;
   logic [7:0]  CMD_LEN = '0;
   logic [2:0]  CMD_SIZE = '0;
   logic [1:0]  CMD_BURST = '0;
   logic        BEAT_VALID;
   logic        BEAT_READY = 1'b1;
   logic [31:0] BEAT_ADDR;
   logic [7:0]  BEAT_IDX;
   logic        BEAT_LAST;
   logic        CMD_ERR;
   logic        BUSY;

   int total = 0;
   int bad = 0;

   axi_burst_addr_seq #(.ADDR_WIDTH(32), .LEN_BITS(8), .MAX_SIZE(3)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_SIZE(CMD_SIZE), .CMD_BURST(CMD_BURST),
      .BEAT_VALID(BEAT_VALID), .BEAT_READY(BEAT_READY),
      .BEAT_ADDR(BEAT_ADDR), .BEAT_IDX(BEAT_IDX), .BEAT_LAST(BEAT_LAST),
      .CMD_ERR(CMD_ERR), .BUSY(BUSY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [1:0]       burst;
      logic [2:0]       size;
      logic [7:0]       len;
      logic [31:0]      addr;
      logic             err;
      logic [4:0]       nb;
      logic [3:0][31:0] exp;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l,
                               input logic [31:0] a, input logic e, input logic [4:0] n,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
      vec_t v;
      v.burst = b; v.size = s; v.len = l; v.addr = a; v.err = e; v.nb = n;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l,
                        input logic [31:0] a);
      int n = 0;
      while (!CMD_READY && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      chk("cmd_ready_before_issue", CMD_READY, 1);
      CMD_VALID = 1'b1; CMD_BURST = b; CMD_SIZE = s; CMD_LEN = l; CMD_ADDR = a;
      @(posedge ACLK); #1;
      // Garbage on the command bus while running must not disturb the burst.
      CMD_VALID = 1'b0; CMD_ADDR = 32'hDEAD_BEEF; CMD_LEN = 8'hFF;
      CMD_SIZE = 3'd7; CMD_BURST = 2'b11;
   endtask

   task automatic beat(input string tag, input logic [31:0] a, input logic [7:0] idx,
                       input logic last);
      chk({tag, "_valid"}, BEAT_VALID, 1);
      chk({tag, "_addr"}, BEAT_ADDR, a);
      chk({tag, "_idx"}, BEAT_IDX, idx);
      chk({tag, "_last"}, BEAT_LAST, last);
      chk({tag, "_busy"}, BUSY, 1);
      @(posedge ACLK); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, CMD_READY, 0);
      chk({tag, "_valid"}, BEAT_VALID, 0);
      chk({tag, "_addr"}, BEAT_ADDR, 0);
      chk({tag, "_idx"}, BEAT_IDX, 0);
      chk({tag, "_last"}, BEAT_LAST, 0);
      chk({tag, "_err"}, CMD_ERR, 0);
      chk({tag, "_busy"}, BUSY, 0);
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = mk(2'b01, 3'd2, 8'd3, 32'h1003, 1'b0, 5'd4, 32'h1003, 32'h1004, 32'h1008, 32'h100C);
      vecs[1] = mk(2'b10, 3'd2, 8'd3, 32'h34,   1'b0, 5'd4, 32'h34, 32'h38, 32'h3C, 32'h30);
      vecs[2] = mk(2'b00, 3'd2, 8'd2, 32'h80,   1'b0, 5'd3, 32'h80, 32'h80, 32'h80, 32'h0);
      vecs[3] = mk(2'b01, 3'd3, 8'd0, 32'h10,   1'b0, 5'd1, 32'h10, 32'h0, 32'h0, 32'h0);
      vecs[4] = mk(2'b10, 3'd3, 8'd1, 32'h48,   1'b0, 5'd2, 32'h48, 32'h40, 32'h0, 32'h0);
      vecs[5] = mk(2'b10, 3'd2, 8'd2, 32'h40,   1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[6] = mk(2'b11, 3'd2, 8'd3, 32'h40,   1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      vecs[7] = mk(2'b01, 3'd4, 8'd1, 32'h40,   1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef BOUNDARY_4K_CHECK_EN
      vecs[8] = mk(2'b01, 3'd2, 8'd3, 32'hFF8,  1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
`else
      vecs[8] = mk(2'b01, 3'd2, 8'd3, 32'hFF8,  1'b0, 5'd4, 32'hFF8, 32'hFFC, 32'h1000, 32'h1004);
`endif

      // Reset state and release.
      #12;
      chk_all_zero("reset");
      #10 ARESET = 1'b0;
      @(posedge ACLK); #1;
      chk("post_reset_ready", CMD_READY, 1);
      chk("post_reset_busy", BUSY, 0);

      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].burst, vecs[i].size, vecs[i].len, vecs[i].addr);
         if (vecs[i].err) begin
            chk($sformatf("v%0d_err_pulse", i), CMD_ERR, 1);
            chk($sformatf("v%0d_err_novalid", i), BEAT_VALID, 0);
            chk($sformatf("v%0d_err_ready", i), CMD_READY, 1);
            @(posedge ACLK); #1;
            chk($sformatf("v%0d_err_drop", i), CMD_ERR, 0);
            chk($sformatf("v%0d_err_novalid2", i), BEAT_VALID, 0);
         end else begin
            for (int b = 0; b < int'(vecs[i].nb); b++)
               beat($sformatf("v%0d_b%0d", i, b), vecs[i].exp[b], 8'(b), b == int'(vecs[i].nb) - 1);
            chk($sformatf("v%0d_end_valid", i), BEAT_VALID, 0);
            chk($sformatf("v%0d_end_ready", i), CMD_READY, 1);
            chk($sformatf("v%0d_end_busy", i), BUSY, 0);
            chk($sformatf("v%0d_end_err", i), CMD_ERR, 0);
         end
      end

      // Stall at beat 2: address must hold, nothing skipped or repeated.
      issue(2'b01, 3'd2, 8'd3, 32'h1003);
      beat("stall_b0", 32'h1003, 8'd0, 1'b0);
      BEAT_READY = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall_c%0d_valid", c), BEAT_VALID, 1);
         chk($sformatf("stall_c%0d_addr", c), BEAT_ADDR, 32'h1004);
         chk($sformatf("stall_c%0d_idx", c), BEAT_IDX, 1);
         @(posedge ACLK); #1;
      end
      BEAT_READY = 1'b1;
      beat("stall_b1", 32'h1004, 8'd1, 1'b0);
      beat("stall_b2", 32'h1008, 8'd2, 1'b0);
      beat("stall_b3", 32'h100C, 8'd3, 1'b1);
      chk("stall_end_valid", BEAT_VALID, 0);

      // Reset mid-burst: outputs clear immediately, burst abandoned.
      issue(2'b01, 3'd2, 8'd3, 32'h1003);
      beat("rst_b0", 32'h1003, 8'd0, 1'b0);
      ARESET = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(posedge ACLK);
      @(posedge ACLK);
      #2 ARESET = 1'b0;
      @(posedge ACLK); #1;
      chk("rel_ready", CMD_READY, 1);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rel_c%0d_novalid", c), BEAT_VALID, 0);
         chk($sformatf("rel_c%0d_busy", c), BUSY, 0);
         @(posedge ACLK); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_burst_addr_seq.md
AXI_BURST_ADDR_SEQ -- requirements
Module: axi_burst_addr_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width in bits (minimum 12).
REQ-002 SHALL have parameter LEN_BITS, default 8, width of the burst-length field (AxLEN, beats minus 1).
REQ-003 SHALL have parameter MAX_SIZE, default 3, the largest legal SIZE code (log2 of bus bytes).
REQ-004 SHALL have port ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARESET  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports CMD_VALID in 1 and CMD_READY out 1, the command handshake.
REQ-007 SHALL have ports CMD_ADDR in ADDR_WIDTH, CMD_LEN in LEN_BITS, CMD_SIZE in 3 and CMD_BURST in 2 (00 FIXED, 01 INCR, 10 WRAP, 11 reserved).
REQ-008 SHALL have ports BEAT_VALID out 1 and BEAT_READY in 1, the beat handshake.
REQ-009 SHALL have ports BEAT_ADDR out ADDR_WIDTH, BEAT_IDX out LEN_BITS and BEAT_LAST out 1.
REQ-010 SHALL have ports CMD_ERR out 1 (one-cycle illegal-command pulse) and BUSY out 1 (a burst is in progress).

Function
REQ-011 SHALL use an FSM with states IDLE and RUN.
REQ-012 SHALL drive CMD_READY high only in IDLE; a command is accepted on the edge where CMD_VALID and CMD_READY are both high.
REQ-013 SHALL treat a command as illegal when any of these holds: BURST is 11; SIZE exceeds MAX_SIZE; BURST is WRAP and LEN is not 1, 3, 7 or 15.
REQ-014 SHALL, on accepting an illegal command, pulse CMD_ERR for exactly the next cycle, stay in IDLE and emit no beats.
REQ-015 SHALL, on accepting a legal command, enter RUN with BEAT_VALID high in the next cycle (1-cycle latency), BEAT_ADDR equal to CMD_ADDR unmodified, and BEAT_IDX equal to 0.
REQ-016 SHALL hold BEAT_ADDR, BEAT_IDX and BEAT_LAST stable while BEAT_VALID is high and BEAT_READY is low.
REQ-017 SHALL, on each beat handshake, advance the address as follows:
  - FIXED: address unchanged.
  - INCR: address aligned down to 2^SIZE, plus 2^SIZE, modulo 2^ADDR_WIDTH.
  - WRAP: same as INCR, then wrapped within the boundary of (LEN+1)*2^SIZE bytes that contains the start address.
REQ-018 SHALL, on each beat handshake, increment BEAT_IDX.
REQ-019 SHALL assert BEAT_LAST exactly when BEAT_IDX equals the latched LEN; LEN=0 yields one beat with BEAT_LAST high.
REQ-020 SHALL, on the last-beat handshake, return to IDLE with BEAT_VALID low and CMD_READY high in the following cycle; no back-to-back accept in the same cycle.
REQ-021 SHALL ignore changes on the CMD_* inputs while in RUN; all command fields are latched at accept.
REQ-022 SHALL drive BUSY high exactly while in RUN.

Reset
REQ-023 SHALL, while ARESET is high, force state IDLE and all outputs (CMD_READY, BEAT_VALID, BEAT_ADDR, BEAT_IDX, BEAT_LAST, CMD_ERR, BUSY) to 0.
REQ-024 SHALL drive CMD_READY high in the first clock cycle after ARESET deasserts.
REQ-025 SHALL, on reset asserted mid-burst, abandon the burst immediately, with no further beats after release.

Configuration
REQ-026 SHALL, with BOUNDARY_4K_CHECK_EN defined, treat an INCR command as illegal when aligned start address[11:0] + (LEN+1)*2^SIZE exceeds 4096 (handled as in REQ-014).
REQ-027 SHALL, without BOUNDARY_4K_CHECK_EN, accept such INCR bursts and let addresses cross the 4KB page.

Structure
REQ-028 SHALL place the burst-type enum, FSM state enum and a size-to-bytes function in shared package axi_burst_pkg.
REQ-029 SHALL compute the next address in a combinational sub-module axi_beat_addr_calc, instantiated once.

Verification
REQ-030 SHALL cover: INCR, ADDR=0x1003, LEN=3, SIZE=2 -> beats 0x1003, 0x1004, 0x1008, 0x100C; BEAT_LAST on beat 4.
REQ-031 SHALL cover: WRAP, ADDR=0x34, LEN=3, SIZE=2 -> beats 0x34, 0x38, 0x3C, 0x30.
REQ-032 SHALL cover: FIXED, ADDR=0x80, LEN=2 -> three beats at 0x80; BEAT_IDX 0, 1, 2.
REQ-033 SHALL cover: BEAT_READY low 5 cycles at beat 2 of REQ-030 -> 0x1004 held, no beat skipped or repeated.
REQ-034 SHALL cover: WRAP with LEN=2, and BURST=11 -> single CMD_ERR pulse, BEAT_VALID stays 0, CMD_READY high next cycle.
REQ-035 SHALL cover: INCR, ADDR=0xFF8, LEN=3, SIZE=2 -> CMD_ERR with the macro; beats 0xFF8, 0xFFC, 0x1000, 0x1004 without it; ARESET asserted at beat 2 -> outputs 0 at once.
